router_out_arbiter: RTL and testbench

//   Output-port scheduler for the NUM_PORTS x NUM_PORTS router.
//   Per-input-port FSMs each raise a request with a decoded 4-bit destination address.

---
 rtl/router_pkg.sv | 15 +
 rtl/router_out_arbiter_rr_pick.sv | 27 ++
 rtl/router_out_arbiter.sv | 101 ++++++++++
 tb/tb_router_out_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router constants and the output-arbiter state encoding.
package router_pkg;

  localparam int NUM_PORTS_DEF = 16;
  localparam int ADDR_W_DEF    = 4;

  localparam logic ARB_IDLE = 1'b0;
  localparam logic ARB_BUSY = 1'b1;

  typedef enum logic {
    ST_IDLE = ARB_IDLE,
    ST_BUSY = ARB_BUSY
  } arb_state_e;

endpackage

// File: rtl/router_out_arbiter_rr_pick.sv
// Round-robin priority select: first set candidate at or after ptr, wrapping.
module rr_pick #(
  parameter int NUM_PORTS = 16,
  parameter int ADDR_W    = 4
) (
  input  logic [NUM_PORTS-1:0] cand,
  input  logic [ADDR_W-1:0]    ptr,
  output logic                 found,
  output logic [ADDR_W-1:0]    idx
);

  // NUM_PORTS is a power of two, so ADDR_W-bit addition wraps modulo NUM_PORTS.
  always_comb begin
    logic [ADDR_W-1:0] j;
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      j = ptr + ADDR_W'(k);
      if (!found && cand[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/router_out_arbiter.sv
// Per-output round-robin scheduler driving the crossbar selects; a grant is held
// for the whole packet, i.e. until the owning input drops its request.
//   state   | meaning
//   ST_IDLE | output free, picking among requesters from ptr onward
//   ST_BUSY | output owned by input out_sel[o] until its req falls
module router_out_arbiter
  import router_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  output logic [NUM_PORTS-1:0]        grant,
  output logic [NUM_PORTS-1:0]        out_active,
  output logic [NUM_PORTS*ADDR_W-1:0] out_sel
);

  // own[o] is the one-hot owner of output o; zero while the output is idle.
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] own;

  always_comb begin
    grant = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      grant = grant | own[o];
    end
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    arb_state_e           state_q, state_d;
    logic [ADDR_W-1:0]    ptr_q, ptr_d;
    logic [ADDR_W-1:0]    sel_q, sel_d;
    logic [NUM_PORTS-1:0] cand;
    logic                 found;
    logic [ADDR_W-1:0]    idx;
    logic                 owner_req;

    // The address is only looked at under req, so an undriven address never propagates.
    always_comb begin
      cand = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (req[i] && !grant[i]) begin
          cand[i] = (req_addr[i*ADDR_W +: ADDR_W] == ADDR_W'(o));
        end
      end
    end

    rr_pick #(
      .NUM_PORTS (NUM_PORTS),
      .ADDR_W    (ADDR_W)
    ) u_rr_pick (
      .cand  (cand),
      .ptr   (ptr_q),
      .found (found),
      .idx   (idx)
    );

    assign owner_req = req[sel_q];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= ST_IDLE;
        ptr_q   <= '0;
        sel_q   <= '0;
      end else begin
        state_q <= state_d;
        ptr_q   <= ptr_d;
        sel_q   <= sel_d;
      end
    end

    // Pointer moves past the owner only on release, so a grant alone never rotates priority.
    always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      case (state_q)
        ST_IDLE: begin
          if (found) begin
            state_d = ST_BUSY;
            sel_d   = idx;
          end
        end
        ST_BUSY: begin
          if (!owner_req) begin
            state_d = ST_IDLE;
            ptr_d   = sel_q + ADDR_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    assign own[o] = (state_q == ST_BUSY) ? (NUM_PORTS'(1) << sel_q) : '0;
    assign out_active[o] = (state_q == ST_BUSY);
    assign out_sel[o*ADDR_W +: ADDR_W] = sel_q;
  end

endmodule

// File: tb/tb_router_out_arbiter.sv
// Scenario bench for router_out_arbiter: expectations queued per stimulus step.
module tb_router_out_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] req;
  logic [63:0] req_addr;
  logic [15:0] grant;
  logic [15:0] out_active;
  logic [63:0] out_sel;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic [15:0] g;
    logic [15:0] a;
    logic [63:0] sm;
    logic [63:0] sv;
  } exp_t;

  exp_t exp_q[$];

  router_out_arbiter #(.NUM_PORTS(16), .ADDR_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_addr   (req_addr),
    .grant      (grant),
    .out_active (out_active),
    .out_sel    (out_sel)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [15:0] b(input int i);
    return 16'(1) << i;
  endfunction

  function automatic logic [63:0] m(input int o);
    logic [63:0] r = '0;
    r[o*4 +: 4] = 4'hf;
    return r;
  endfunction

  function automatic logic [63:0] s(input int o, input int v);
    logic [63:0] r = '0;
    r[o*4 +: 4] = 4'(v);
    return r;
  endfunction

  task automatic set_req(input int i, input int a);
    req[i] = 1'b1;
    req_addr[i*4 +: 4] = 4'(a);
  endtask

  task automatic clr_req(input int i);
    req[i] = 1'b0;
    req_addr[i*4 +: 4] = 4'bxxxx;
  endtask

  task automatic step(input string tag, input logic [15:0] g, input logic [15:0] a,
                      input logic [63:0] sm, input logic [63:0] sv);
    exp_t e;
    exp_q.push_back('{tag, g, a, sm, sv});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({e.tag, "_grant"}, {48'd0, grant}, {48'd0, e.g});
    chk({e.tag, "_active"}, {48'd0, out_active}, {48'd0, e.a});
    if (e.sm != '0) chk({e.tag, "_sel"}, out_sel & e.sm, e.sv);
  endtask

  initial begin
    logic [63:0] sv5;
    reset    = 1'b1;
    req      = '0;
    req_addr = '0;
    #3;
    chk("rst_grant", {48'd0, grant}, 64'd0);
    chk("rst_active", {48'd0, out_active}, 64'd0);
    chk("rst_sel", out_sel, 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Reset in the middle of a packet drops everything without a clock edge.
    set_req(7, 1);
    step("t1_pre", b(7), b(1), m(1), s(1, 7));
    #2 reset = 1'b1;
    #1;
    chk("t1_async_grant", {48'd0, grant}, 64'd0);
    chk("t1_async_active", {48'd0, out_active}, 64'd0);
    chk("t1_async_sel", out_sel, 64'd0);
    clr_req(7);
    @(posedge clk);
    #1 reset = 1'b0;
    set_req(3, 5);
    step("t1_grant", b(3), b(5), m(5), s(5, 3));
    clr_req(3);
    step("t1_rel", 16'd0, 16'd0, m(5), s(5, 3));

    // Contention on output 2 from a zero pointer.
    set_req(1, 2); set_req(4, 2); set_req(9, 2);
    step("t2_a", b(1), b(2), m(2), s(2, 1));
    step("t2_b", b(1), b(2), m(2), s(2, 1));
    clr_req(1);
    step("t2_rel1", 16'd0, 16'd0, m(2), s(2, 1));
    step("t2_g4", b(4), b(2), m(2), s(2, 4));
    clr_req(4);
    step("t2_rel4", 16'd0, 16'd0, m(2), s(2, 4));
    step("t2_g9", b(9), b(2), m(2), s(2, 9));
    clr_req(9);
    step("t2_rel9", 16'd0, 16'd0, 64'd0, 64'd0);

    // Pointer wrap: release of 13 leaves ptr[7]=14, so 15 beats 2.
    set_req(13, 7);
    step("t3_g13", b(13), b(7), m(7), s(7, 13));
    clr_req(13);
    step("t3_rel13", 16'd0, 16'd0, 64'd0, 64'd0);
    set_req(2, 7); set_req(15, 7);
    step("t3_g15", b(15), b(7), m(7), s(7, 15));
    clr_req(15);
    step("t3_rel15", 16'd0, 16'd0, m(7), s(7, 15));
    step("t3_g2", b(2), b(7), m(7), s(7, 2));
    clr_req(2);
    step("t3_rel2", 16'd0, 16'd0, 64'd0, 64'd0);

    // Long hold with a competing requester and an owner address change.
    set_req(6, 0);
    step("t4_g6", b(6), b(0), m(0), s(0, 6));
    set_req(8, 0);
    for (int k = 0; k < 40; k++) begin
      if (k == 20) req_addr[6*4 +: 4] = 4'd3;
      step("t4_hold", b(6), b(0), m(0), s(0, 6));
    end
    clr_req(6);
    step("t4_rel6", 16'd0, 16'd0, 64'd0, 64'd0);
    step("t4_g8", b(8), b(0), m(0), s(0, 8));
    clr_req(8);
    step("t4_rel8", 16'd0, 16'd0, 64'd0, 64'd0);

    // All inputs to distinct outputs in one cycle.
    sv5 = '0;
    for (int i = 0; i < 16; i++) begin
      set_req(i, (i + 1) % 16);
      sv5[i*4 +: 4] = 4'((i + 15) % 16);
    end
    step("t5_all", 16'hffff, 16'hffff, {64{1'b1}}, sv5);
    for (int i = 0; i < 16; i++) clr_req(i);
    step("t5_rel", 16'd0, 16'd0, {64{1'b1}}, sv5);

    // Unknown address on an idle input must not leak.
    req[10] = 1'b0;
    req_addr[10*4 +: 4] = 4'bxxxx;
    set_req(11, 0);
    step("t6_g11", b(11), b(0), m(0), s(0, 11));
    chk("t6_nox", {63'd0, $isunknown({grant, out_active, out_sel})}, 64'd0);
    clr_req(11);
    step("t6_rel", 16'd0, 16'd0, 64'd0, 64'd0);

    // Release on one output alongside a grant on another, then a same-edge re-request.
    set_req(5, 3);
    step("t7_g5", b(5), b(3), m(3), s(3, 5));
    clr_req(5);
    set_req(12, 9);
    step("t7_g12", b(12), b(9), m(9), s(9, 12));
    clr_req(12);
    set_req(1, 9);
    step("t7_wait", 16'd0, 16'd0, m(9), s(9, 12));
    step("t7_g1", b(1), b(9), m(9), s(9, 1));
    clr_req(1);
    step("t7_rel", 16'd0, 16'd0, 64'd0, 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
